// File: rtl/rng_request_arbiter.sv
// rng_request_arbiter: round-robin sharing of one LFSR/counter source; tap snapshot ports enabled by RNG_TAP_SNAPSHOT_EN
module rng_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SETTLE_CYCLES = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_mode,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_data,
  input  logic               rsp_ready,
  output logic               src_is_lfsr,
  input  logic [31:0]        src_out,
  output logic               busy
`ifdef RNG_TAP_SNAPSHOT_EN
  ,
  input  logic [3:0]         cfg_tap_index,
  output logic [3:0]         src_tap_index,
  input  logic [3:0]         src_tap_output,
  output logic [3:0]         rsp_tap
`endif
);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;
  localparam logic [IDW:0] NR = (IDW+1)'(NUM_REQ);
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, rsp_id_q, rsp_id_d, win;
  logic [IDW:0] sum;
  logic [3:0] cnt_q, cnt_d;
  logic src_is_lfsr_q, src_is_lfsr_d, rsp_valid_q, rsp_valid_d, found, chg;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [3:0] tap_idx_q, tap_idx_d, rsp_tap_q, rsp_tap_d;
  // first asserted request scanning from ptr, wrapping
  always_comb begin
    found = 1'b0;
    win = '0;
    sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(i);
      sum = (sum >= NR) ? sum - NR : sum;
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found = 1'b1;
        win = sum[IDW-1:0];
      end
    end
  end
  // next-state: grant in IDLE, settle after a source reconfiguration, capture, hold response
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    src_is_lfsr_d = src_is_lfsr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_data_d = rsp_data_q;
    tap_idx_d = tap_idx_q;
    rsp_tap_d = rsp_tap_q;
    chg = 1'b0;
    unique case (state_q)
      IDLE: if (found) begin
        chg = req_mode[win] != src_is_lfsr_q;
`ifdef RNG_TAP_SNAPSHOT_EN
        chg = chg || (cfg_tap_index != tap_idx_q);
        tap_idx_d = cfg_tap_index;
`endif
        rsp_id_d = win;
        src_is_lfsr_d = req_mode[win];
        cnt_d = 4'(SETTLE_CYCLES);
        state_d = chg ? SETTLE : CAPTURE;
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? CAPTURE : SETTLE;
      end
      CAPTURE: begin
        rsp_data_d = src_out;
`ifdef RNG_TAP_SNAPSHOT_EN
        rsp_tap_d = src_tap_output;
`endif
        rsp_valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        ptr_d = (rsp_id_q == IDW'(NUM_REQ-1)) ? '0 : rsp_id_q + IDW'(1);
        state_d = IDLE;
      end
    endcase
  end
  // state registers, async reset back to LFSR mode with no pending response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      src_is_lfsr_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      tap_idx_q <= '0;
      rsp_tap_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      src_is_lfsr_q <= src_is_lfsr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      tap_idx_q <= tap_idx_d;
      rsp_tap_q <= rsp_tap_d;
    end
  assign req_ready = (state_q == IDLE && found) ? NUM_REQ'(1) << win : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign src_is_lfsr = src_is_lfsr_q;
  assign busy = state_q != IDLE;
`ifdef RNG_TAP_SNAPSHOT_EN
  assign src_tap_index = tap_idx_q;
  assign rsp_tap = rsp_tap_q;
`endif
endmodule

// File: tb/tb_rng_request_arbiter.sv
// tb_rng_request_arbiter: directed and randomized checks against a transaction-level model
module tb_rng_request_arbiter;
  localparam int N = 4;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_mode = '0, req_ready, last_rdy;
  logic rsp_valid, rsp_ready = 1'b1, src_is_lfsr, busy;
  logic [1:0] rsp_id;
  logic [31:0] rsp_data, src;
  int pass_cnt = 0, total_cnt = 0, n_done = 0;
  int exp_order [8] = '{0, 1, 2, 3, 0, 2, 3, 2};
`ifdef RNG_TAP_SNAPSHOT_EN
  logic [3:0] cfg_tap_index = '0, src_tap_index, src_tap_output, rsp_tap;
  assign src_tap_output = 4'(src >> src_tap_index);
`endif

  rng_request_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_mode(req_mode),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .src_is_lfsr(src_is_lfsr),
    .src_out(src), .busy(busy)
`ifdef RNG_TAP_SNAPSHOT_EN
    , .cfg_tap_index(cfg_tap_index), .src_tap_index(src_tap_index),
    .src_tap_output(src_tap_output), .rsp_tap(rsp_tap)
`endif
  );

  always #5 clk = ~clk;

  // free-running source: Galois-free Fibonacci LFSR or up-counter
  always @(posedge clk or negedge rst_n)
    if (!rst_n) src <= 32'hFFFF_FFFF;
    else src <= src_is_lfsr ? {src[30:0], src[31] ^ src[21] ^ src[1] ^ src[0]} : src + 32'd1;

  always @(negedge clk) last_rdy <= req_ready;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask

  // transaction-level model: one outstanding request, timestamps for capture and response
  longint cyc = 0, cap = 0;
  bit act = 0, m_mode = 1;
  int m_ptr = 0, m_id = 0;
  logic [31:0] e_data = '0;
  logic [3:0] m_tap = '0, e_tap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int scan();
    for (int i = 0; i < N; i++) if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    bit sw;
    if (!rst_n) begin
      act = 0; m_mode = 1; m_ptr = 0; m_id = 0; e_data = '0; m_tap = '0; e_tap = '0;
    end else begin
      w = scan();
      chk("m_req_ready", 32'(req_ready), (act || w < 0) ? 32'd0 : 32'd1 << w);
      chk("m_busy", 32'(busy), 32'(act));
      chk("m_src_is_lfsr", 32'(src_is_lfsr), 32'(m_mode));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(act && cyc > cap));
      chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
      chk("m_rsp_data", rsp_data, e_data);
`ifdef RNG_TAP_SNAPSHOT_EN
      chk("m_src_tap_index", 32'(src_tap_index), 32'(m_tap));
      chk("m_rsp_tap", 32'(rsp_tap), 32'(e_tap));
`endif
      if (!act) begin
        if (w >= 0) begin
          act = 1;
          m_id = w;
          sw = req_mode[w] != m_mode;
`ifdef RNG_TAP_SNAPSHOT_EN
          sw = sw || (cfg_tap_index != m_tap);
          m_tap = cfg_tap_index;
`endif
          m_mode = req_mode[w];
          cap = cyc + 1 + (sw ? S : 0);
        end
      end else if (cyc == cap) begin
        e_data = src;
`ifdef RNG_TAP_SNAPSHOT_EN
        e_tap = src_tap_output;
`endif
      end else if (cyc > cap && rsp_ready) begin
        act = 0;
        m_ptr = (m_id + 1) % N;
        n_done++;
      end
    end
  end

  task automatic wait_grant(output int w);
    w = -1;
    for (int k = 0; k < 50 && w < 0; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) w = i;
    end
    if (w < 0) chk("grant_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_seen", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_lfsr", 32'(src_is_lfsr), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w, lat, l2;
    logic [31:0] x, d0;
    logic [1:0] id0;
    do_reset();
    @(posedge clk); #1 req_valid = 4'b0001; req_mode = 4'b0001;
    wait_grant(w);
    chk("t1_grant", 32'(w), 32'd0);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(lat);
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_id", 32'(rsp_id), 32'd0);
    wait_idle();
    @(posedge clk); #1 req_valid = 4'b0010; req_mode = 4'b0000;
    wait_grant(w);
    chk("t2_grant", 32'(w), 32'd1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("t2_mode", 32'(src_is_lfsr), 32'd0);
    x = src;
    wait_rsp(l2);
    chk("t2_latency", 32'(l2 + 1), 32'(S + 2));
    chk("t2_data", rsp_data, x + 32'd2);
    chk("t2_id", 32'(rsp_id), 32'd1);
    wait_idle();
    do_reset();
    @(posedge clk); #1 req_valid = 4'b1111; req_mode = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      wait_grant(w);
      chk($sformatf("rr_%0d", j), 32'(w), 32'(exp_order[j]));
      if (j == 4) begin
        @(posedge clk); #1 req_valid = 4'b1100;
      end
    end
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    @(posedge clk); #1 rsp_ready = 1'b0; req_valid = 4'b0001;
    wait_grant(w);
    @(posedge clk); #1 req_valid = 4'b1110;
    wait_rsp(lat);
    d0 = rsp_data;
    id0 = rsp_id;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, d0);
      chk("bp_id", 32'(rsp_id), 32'(id0));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_valid_low", 32'(rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    @(posedge clk); #1 req_valid = 4'b0100; req_mode = 4'b0000;
    wait_grant(w);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("mr_settle", 32'(src_is_lfsr), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_lfsr", 32'(src_is_lfsr), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_valid", 32'(rsp_valid), 32'd0);
    chk("mr_id", 32'(rsp_id), 32'd0);
    chk("mr_data", rsp_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("mr_no_stale", 32'(rsp_valid), 32'd0);
      chk("mr_lfsr_hold", 32'(src_is_lfsr), 32'd1);
    end
`ifdef RNG_TAP_SNAPSHOT_EN
    @(posedge clk); #1 req_valid = 4'b0001; req_mode = 4'b0001; cfg_tap_index = 4'd5;
    wait_grant(w);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("tap_index", 32'(src_tap_index), 32'd5);
    wait_rsp(l2);
    chk("tap_latency", 32'(l2 + 1), 32'(S + 2));
    wait_idle();
`endif
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~last_rdy;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_mode[i] = 1'($urandom_range(0, 1));
        end else if (req_valid[i] && $urandom_range(0, 49) == 0) req_valid[i] = 1'b0;
      end
      rsp_ready = $urandom_range(0, 3) != 0;
`ifdef RNG_TAP_SNAPSHOT_EN
      if ($urandom_range(0, 7) == 0) cfg_tap_index = 4'($urandom_range(0, 15));
`endif
    end
    chk("progress", 32'(n_done > 100), 32'd1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/rng_request_arbiter.md
Name: rng_request_arbiter

Overview:
- Shares one 32-bit LFSR/counter source between NUM_REQ requesters.
- Arbitrates requests round-robin and switches the source between LFSR and counter mode as each request needs.
- Waits a settle interval after each mode switch, then returns one captured 32-bit sample per granted request over a valid/ready response channel.
- Sits between the free-running source and its consumers, e.g. pattern generators and seed loaders.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SETTLE_CYCLES, 2, source clock cycles to wait after a mode change before sampling (1..15).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request strobe, held high until granted.
- req_mode  input  NUM_REQ  per-requester mode: 1 = LFSR sample, 0 = counter sample. Stable while req_valid is high.
- req_ready  output  NUM_REQ  one-hot grant, combinational, only in IDLE.
- rsp_valid  output  1  response data valid.
- rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the response.
- rsp_data  output  32  captured source word.
- rsp_ready  input  1  consumer accepts the response.
- src_is_lfsr  output  1  mode control driven to the source.
- src_out  input  32  source register value.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, src_is_lfsr = 1, rsp_valid = 0, rsp_data = 0, rsp_id = 0.
  - Round-robin pointer ptr = 0, settle counter = 0.
- Arbitration, in IDLE only:
  - Winner w is the first asserted req_valid scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[w] = 1 in the same cycle; all other req_ready bits are 0. Outside IDLE, req_ready = 0.
  - On grant, register rsp_id = w and the requested mode m = req_mode[w].
  - If m differs from src_is_lfsr: src_is_lfsr <= m, counter <= SETTLE_CYCLES, go to SETTLE.
  - Otherwise go to CAPTURE.
- SETTLE:
  - Counter decrements each cycle.
  - When counter == 1, go to CAPTURE.
  - src_is_lfsr holds its new value.
- CAPTURE (one cycle):
  - rsp_data <= src_out, rsp_valid <= 1.
  - Go to RESP.
- RESP:
  - rsp_data, rsp_id and rsp_valid hold until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid <= 0, ptr <= (rsp_id + 1) mod NUM_REQ, go to IDLE.
  - rsp_ready while rsp_valid == 0 is ignored.
- Latency, measured from the grant edge:
  - Same mode: rsp_valid rises 2 edges after grant.
  - Mode switch: rsp_valid rises SETTLE_CYCLES + 2 edges after grant.
  - At least one IDLE cycle separates consecutive grants, so same-mode throughput is 1 response per 3 cycles when rsp_ready is tied high.
- Boundaries:
  - No request in IDLE: outputs hold, src_is_lfsr unchanged.
  - Requests arriving outside IDLE wait. They are never dropped while held.
  - A requester that deasserts req_valid before its grant is simply skipped.
  - ptr advances only on response completion, so every requester is served within NUM_REQ grants.
  - rst_n asserted mid-operation:
    - Immediate return to reset values; the pending response is discarded and no rsp_valid is emitted for it.
    - src_is_lfsr returns to 1.

Optional Feature:
- Macro: RNG_TAP_SNAPSHOT_EN.
- With the macro defined, add these ports:
  - cfg_tap_index (input, 4): tap selection from the requester.
  - src_tap_index (output, 4): tap selection driven to the source.
  - src_tap_output (input, 4): 4-bit tap value from the source.
  - rsp_tap (output, 4): captured tap value returned with the response.
- Feature behaviour with the macro:
  - cfg_tap_index is registered into src_tap_index at grant.
  - A change of src_tap_index also forces the SETTLE path, even with an unchanged mode.
  - rsp_tap is captured from src_tap_output in CAPTURE, alongside rsp_data.
  - Reset values: src_tap_index = 0, rsp_tap = 0.
- Without the macro: these ports do not exist and behaviour is exactly as above.

Test Plan:
- Reset checks, plus source model reset to 0xFFFFFFFF in LFSR mode:
  - Release reset: src_is_lfsr = 1, rsp_valid = 0, busy = 0.
  - req_valid[0] = 1, req_mode[0] = 1 -> req_ready[0] pulses 1 cycle, rsp_valid 2 edges later, rsp_id = 0, rsp_data equals the model's src_out at the CAPTURE edge.
- Mode switch, SETTLE_CYCLES = 2:
  - req_valid[1] = 1, req_mode[1] = 0 -> src_is_lfsr falls the edge after grant, rsp_valid 4 edges after grant.
  - rsp_data equals the model counter value at capture (previous value + 1 each cycle after the switch).
- Round-robin fairness:
  - All 4 requesters held high, rsp_ready = 1 -> grant order 0, 1, 2, 3, 0, with rsp_id following that order.
  - Then only requesters 2 and 3 high after requester 2 is served -> grant order 3, 2.
- Backpressure:
  - rsp_ready = 0 for 10 cycles -> rsp_valid, rsp_data and rsp_id stable, req_ready = 0 throughout, busy = 1.
  - Raise rsp_ready -> handshake completes and IDLE follows on the next edge.
- Reset mid-operation:
  - Assert rst_n low asynchronously, between edges, while in SETTLE -> outputs take reset values immediately.
  - After release, no stale rsp_valid appears and src_is_lfsr = 1.
- RNG_TAP_SNAPSHOT_EN build:
  - Same mode with cfg_tap_index changed 0 -> 5 -> SETTLE is entered and src_tap_index = 5.
  - rsp_tap equals the source model's tap value at the CAPTURE edge.
